bsg_round_robin_packet_arb: RTL and testbench



---
 rtl/bsg_round_robin_packet_arb.sv | 133 +++++++++++++
 tb/tb_bsg_round_robin_packet_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_round_robin_packet_arb.sv
// bsg_round_robin_packet_arb
//
// Merges num_in_p valid/yumi input streams onto one output stream, arbitrating
// round-robin at packet granularity. A header beat carries the number of body
// beats that follow in its low len_width_p bits; once a header is accepted the
// winning stream owns the output until its last body beat is accepted, so
// beats of different packets never interleave.
//
// Ports:
//   clk_i     - clock
//   reset_i   - synchronous, active-high reset
//   data_i    - input beats, stream k at [k*width_p +: width_p]
//   v_i       - per-stream valid
//   yumi_o    - per-stream dequeue (one-hot or zero)
//   v_o       - output beat valid
//   data_o    - selected beat (0 when nothing is selectable)
//   tag_o     - index of the selected stream (0 when nothing is selectable)
//   header_o  - current output beat is a packet header
//   yumi_i    - consumer accepts the output beat (only while v_o is high)
//
// All output paths are combinational; state advances only on accepted beats.

module bsg_round_robin_packet_arb #(
    parameter int num_in_p       = 4,
    parameter int width_p        = 16,
    parameter int len_width_p    = 4,
    localparam int tag_width_lp  = $clog2(num_in_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_in_p*width_p-1:0]  data_i,
    input  logic [num_in_p-1:0]          v_i,
    output logic [num_in_p-1:0]          yumi_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [tag_width_lp-1:0]      tag_o,
    output logic                         header_o,
    input  logic                         yumi_i
);

    logic                    locked_q, locked_d;
    logic [tag_width_lp-1:0] owner_q,  owner_d;
    logic [len_width_p-1:0]  remain_q, remain_d;
    logic [tag_width_lp-1:0] last_q,   last_d;

    logic [width_p-1:0]      beats [num_in_p];
    logic [tag_width_lp-1:0] rr_cand;
    logic [tag_width_lp-1:0] rr_win;
    logic                    rr_found;
    logic [tag_width_lp-1:0] sel;
    logic                    accept;
    logic [len_width_p-1:0]  hdr_len;

    always_comb begin
        for (int k = 0; k < num_in_p; k++) begin
            beats[k] = data_i[k*width_p +: width_p];
        end
    end

    // Round-robin search: first valid stream strictly after last_q, wrapping,
    // so the previous winner ends up with lowest priority.
    always_comb begin
        rr_cand  = '0;
        rr_win   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= num_in_p; i++) begin
            rr_cand = tag_width_lp'((int'(last_q) + i) % num_in_p);
            if (!rr_found && v_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_win   = rr_cand;
            end
        end
    end

    always_comb begin
        sel      = locked_q ? owner_q : rr_win;
        v_o      = locked_q ? v_i[owner_q] : rr_found;
        header_o = !locked_q && rr_found;
        // While locked the owner's beat is shown even if it is not valid;
        // with nothing selectable the data and tag are forced to 0.
        if (locked_q || rr_found) begin
            data_o = beats[sel];
            tag_o  = sel;
        end else begin
            data_o = '0;
            tag_o  = '0;
        end
        accept = yumi_i && v_o;
        for (int k = 0; k < num_in_p; k++) begin
            yumi_o[k] = accept && (sel == tag_width_lp'(k));
        end
        hdr_len = data_o[len_width_p-1:0];
    end

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        remain_d = remain_q;
        last_d   = last_q;
        if (accept) begin
            if (locked_q) begin
                // remain_q is at least 1 here, so the decrement cannot wrap;
                // the beat that takes it to 0 releases the lock.
                remain_d = remain_q - 1'b1;
                if (remain_q == len_width_p'(1)) begin
                    locked_d = 1'b0;
                end
            end else begin
                last_d = rr_win;
                if (hdr_len != '0) begin
                    locked_d = 1'b1;
                    owner_d  = rr_win;
                    remain_d = hdr_len;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
            remain_q <= '0;
            last_q   <= tag_width_lp'(num_in_p - 1);
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            remain_q <= remain_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_bsg_round_robin_packet_arb.sv
// Testbench for bsg_round_robin_packet_arb (num_in_p=4, width_p=16,
// len_width_p=4). A table of directed vectors covers reset, round-robin order,
// locking, owner stalls, the maximum length and reset mid-packet; a random
// phase then compares every cycle against a small reference model and checks
// packet integrity, fairness and one-hot dequeue.

module tb_bsg_round_robin_packet_arb;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int LW = 4;

    logic           clk = 1'b0;
    logic           reset_i = 1'b0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   v_i = '0;
    logic [N-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     tag_o;
    logic           header_o;
    logic           yumi_i = 1'b0;

    bsg_round_robin_packet_arb #(
        .num_in_p    (N),
        .width_p     (W),
        .len_width_p (LW)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .data_i   (data_i),
        .v_i      (v_i),
        .yumi_o   (yumi_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .tag_o    (tag_o),
        .header_o (header_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o low");
        end
    end

    typedef struct {
        logic           rst;
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           yumi;
        logic           chk;
        logic           ev;
        logic [1:0]     etag;
        logic           ehdr;
        logic [N-1:0]   eyumi;
        logic [W-1:0]   edata;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [W-1:0] hd(int k, int len);
        return {4'hA, 4'(k), 4'h0, 4'(len)};
    endfunction

    function automatic logic [W-1:0] bd(int k, int i);
        return {4'hB, 4'(k), 4'(i), 4'hF};
    endfunction

    function automatic logic [N*W-1:0] p4(logic [W-1:0] d0, logic [W-1:0] d1,
                                          logic [W-1:0] d2, logic [W-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic yumi, input logic chk, input logic ev, input int etag,
                       input logic ehdr, input logic [N-1:0] eyumi, input logic [W-1:0] edata);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.yumi = yumi; r.chk = chk;
        r.ev = ev; r.etag = 2'(etag); r.ehdr = ehdr; r.eyumi = eyumi; r.edata = edata;
        vecs.push_back(r);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_table();
        // reset, then the reset state with nothing valid
        add(1, 4'b0000, '0, 0, 0, 0, 0, 0, 4'b0000, '0);
        add(0, 4'b0000, '0, 0, 1, 0, 0, 0, 4'b0000, '0);
        // all four streams with single-beat packets: strict rotation 0..3
        for (int k = 0; k < N; k++)
            add(0, 4'b1111, p4(hd(0,0), hd(1,0), hd(2,0), hd(3,0)), 1, 1,
                1, k, 1, 4'(1 << k), hd(k,0));
        // stream 1 locks for 3 body beats while stream 2 waits
        add(0, 4'b0110, p4('0, hd(1,3), hd(2,0), '0), 1, 1, 1, 1, 1, 4'b0010, hd(1,3));
        for (int i = 0; i < 3; i++)
            add(0, 4'b0110, p4('0, bd(1,i), hd(2,0), '0), 1, 1, 1, 1, 0, 4'b0010, bd(1,i));
        add(0, 4'b0110, p4('0, hd(1,0), hd(2,0), '0), 1, 1, 1, 2, 1, 4'b0100, hd(2,0));
        // stream 0 locks (L=2), stalls two cycles while stream 3 is valid
        add(0, 4'b0001, p4(hd(0,2), '0, '0, '0), 1, 1, 1, 0, 1, 4'b0001, hd(0,2));
        for (int i = 0; i < 2; i++)
            add(0, 4'b1000, p4(bd(0,0), '0, '0, hd(3,0)), 0, 1, 0, 0, 0, 4'b0000, bd(0,0));
        for (int i = 0; i < 2; i++)
            add(0, 4'b1001, p4(bd(0,i), '0, '0, hd(3,0)), 1, 1, 1, 0, 0, 4'b0001, bd(0,i));
        add(0, 4'b1001, p4(hd(0,0), '0, '0, hd(3,0)), 1, 1, 1, 3, 1, 4'b1000, hd(3,0));
        // maximum length: header + 15 body beats, stream 1 must wait
        add(0, 4'b0001, p4(hd(0,15), hd(1,0), '0, '0), 1, 1, 1, 0, 1, 4'b0001, hd(0,15));
        for (int i = 0; i < 15; i++)
            add(0, 4'b0011, p4(bd(0,i), hd(1,0), '0, '0), 1, 1, 1, 0, 0, 4'b0001, bd(0,i));
        add(0, 4'b0011, p4(hd(0,0), hd(1,0), '0, '0), 1, 1, 1, 1, 1, 4'b0010, hd(1,0));
        // reset after one of three body beats, with a simultaneous accept
        add(0, 4'b0110, p4('0, hd(1,0), hd(2,3), '0), 1, 1, 1, 2, 1, 4'b0100, hd(2,3));
        add(0, 4'b0110, p4('0, hd(1,0), bd(2,0), '0), 1, 1, 1, 2, 0, 4'b0100, bd(2,0));
        add(1, 4'b0110, p4('0, hd(1,0), bd(2,1), '0), 1, 1, 1, 2, 0, 4'b0100, bd(2,1));
        add(0, 4'b0110, p4('0, hd(1,0), bd(2,1), '0), 1, 1, 1, 1, 1, 4'b0010, hd(1,0));
    endtask

    // random-phase state
    logic [W-1:0] src_beat [N];
    logic         src_hdr  [N];
    int           src_left [N];
    int           wait_cnt [N];
    logic         m_locked;
    int           m_owner, m_remain, m_last;
    int           pk_left, pk_owner;
    int           esel, j;
    logic         ev, eh;
    logic [W-1:0] edata;
    logic [N-1:0] eyumi;
    logic [2*N-1:0] dbl;

    task automatic new_header(input int k);
        int len;
        len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
        src_beat[k] = {4'hA, 4'(k), 4'($urandom), 4'(len)};
        src_hdr[k]  = 1'b1;
        src_left[k] = len;
    endtask

    task automatic consume(input int k);
        if (src_hdr[k]) begin
            src_hdr[k] = 1'b0;
            if (src_left[k] == 0) new_header(k);
            else src_beat[k] = 16'($urandom);
        end else begin
            src_left[k]--;
            if (src_left[k] == 0) new_header(k);
            else src_beat[k] = 16'($urandom);
        end
    endtask

    initial begin
        build_table();

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset_i = vecs[i].rst;
            v_i     = vecs[i].v;
            data_i  = vecs[i].d;
            yumi_i  = vecs[i].yumi;
            sb.push_back(vecs[i]);
            n_vec++;
            #3;
            cur = sb.pop_front();
            if (cur.chk) begin
                cmp($sformatf("vec%0d v_o", i), 64'(v_o), 64'(cur.ev));
                cmp($sformatf("vec%0d tag_o", i), 64'(tag_o), 64'(cur.etag));
                cmp($sformatf("vec%0d header_o", i), 64'(header_o), 64'(cur.ehdr));
                cmp($sformatf("vec%0d yumi_o", i), 64'(yumi_o), 64'(cur.eyumi));
                cmp($sformatf("vec%0d data_o", i), 64'(data_o), 64'(cur.edata));
            end
        end

        // random phase
        @(posedge clk); #1;
        reset_i = 1'b1; v_i = '0; yumi_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            new_header(k);
            wait_cnt[k] = 0;
        end
        m_locked = 1'b0; m_owner = 0; m_remain = 0; m_last = N - 1;
        pk_left = 0; pk_owner = 0;

        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            reset_i = 1'b0;
            for (int k = 0; k < N; k++) v_i[k] = ($urandom_range(0, 9) < 7);
            data_i = {src_beat[3], src_beat[2], src_beat[1], src_beat[0]};
            #1;
            yumi_i = v_o && ($urandom_range(0, 3) != 0);
            #2;
            n_vec++;

            if (m_locked) begin
                esel = m_owner;
                ev   = v_i[esel];
                eh   = 1'b0;
            end else begin
                dbl = {v_i, v_i} >> (m_last + 1);
                j = 0;
                for (int t = N - 1; t >= 0; t--) if (dbl[t]) j = t;
                ev   = |v_i;
                eh   = ev;
                esel = ev ? (m_last + 1 + j) % N : 0;
            end
            edata = (m_locked || ev) ? src_beat[esel] : '0;
            eyumi = (yumi_i && ev) ? N'(1 << esel) : '0;

            cmp("rnd v_o", 64'(v_o), 64'(ev));
            cmp("rnd tag_o", 64'(tag_o), 64'(esel));
            cmp("rnd header_o", 64'(header_o), 64'(eh));
            cmp("rnd data_o", 64'(data_o), 64'(edata));
            cmp("rnd yumi_o", 64'(yumi_o), 64'(eyumi));
            cmp("rnd yumi_o onehot", 64'($countones(yumi_o) <= 1), 64'(1));

            if (yumi_i && v_o) begin
                if (pk_left > 0) begin
                    cmp("rnd body owner", 64'(tag_o), 64'(pk_owner));
                    cmp("rnd body not header", 64'(header_o), 64'(0));
                    pk_left--;
                end else begin
                    cmp("rnd expect header", 64'(header_o), 64'(1));
                    pk_left  = int'(data_o[LW-1:0]);
                    pk_owner = int'(tag_o);
                    for (int k = 0; k < N; k++) begin
                        if (k == int'(tag_o)) wait_cnt[k] = 0;
                        else if (v_i[k]) wait_cnt[k]++;
                        else wait_cnt[k] = 0;
                        cmp($sformatf("rnd fairness s%0d", k), 64'(wait_cnt[k] <= N - 1), 64'(1));
                    end
                end
            end

            if (yumi_i && ev) begin
                if (m_locked) begin
                    m_remain--;
                    if (m_remain == 0) m_locked = 1'b0;
                end else begin
                    m_last = esel;
                    if (edata[LW-1:0] != '0) begin
                        m_locked = 1'b1;
                        m_owner  = esel;
                        m_remain = int'(edata[LW-1:0]);
                    end
                end
            end

            for (int k = 0; k < N; k++) if (yumi_o[k]) consume(k);
        end

        @(posedge clk); #1;
        yumi_i = 1'b0;
        v_i    = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
